// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Byte-lane merge: lanes with be[i]=1 take the new byte, others keep the old.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < WORD_BYTES; i++)
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port word RAM with per-byte write enables.
// Read is read-before-write: rdata shows the word as it was before the
// write on the same edge. No reset; contents survive reset.
module mem_word_array
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_W-1:0]     index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane so each lane owns its own write enable.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] q;

    // Lane access: capture old byte, then overwrite it if enabled.
    always_ff @(posedge clk) begin
      if (en) begin
        q <= mem[index];
        if (we && be[i]) mem[index] <= wdata[8*i +: 8];
      end
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the load/store request interface.
// Accepts a request in IDLE, counts WAIT_CYCLES wait states, performs the
// access on the edge where the counter is zero, and pulses ready for one
// cycle. Misaligned or out-of-range addresses skip the array and report err.
module mips_data_mem_responder
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               latch;

  // Request holding registers, loaded on accept.
  logic [31:0]        addr_r;
  logic               we_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [3:0]         be_r;

  logic [DATA_W-1:0]  rdata_hold;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  resp_word;
  logic [ADDR_W-1:0]  index;
  logic               addr_err;
  logic               access;
  logic               ram_en;

  // Address decode on the latched request; stable from accept to response.
  assign index    = addr_r[ADDR_W+1:2];
  assign addr_err = (addr_r[1:0] != 2'b00) || ((addr_r >> (ADDR_W + 2)) != 32'd0);

  // Access edge is the WAIT edge with the counter at zero. Gating with reset
  // makes a reset coincident with that edge win: nothing is written.
  assign access = (state == WAIT) && (cnt == '0);
  assign ram_en = access && !addr_err && reset;

  mem_word_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_r),
    .be    (be_r),
    .index (index),
    .wdata (wdata_r),
    .rdata (ram_q)
  );

  // Response word: zero on error, merged word for stores, raw word for loads.
  // be=0000 on a store merges nothing, so the current word comes back.
  always_comb begin
    resp_word = '0;
    if (!addr_err)
      resp_word = we_r ? merge_word(ram_q, wdata_r, be_r) : ram_q;
  end

  // Outputs: ready/err only in RESP; rdata otherwise holds the last response.
  assign ready = (state == RESP);
  assign err   = ready && addr_err;
  assign rdata = ready ? resp_word : rdata_hold;

  // Next-state and counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch    = 1'b1;
          cnt_nx   = CNT_W'(WAIT_CYCLES);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) cnt_nx   = cnt - 1'b1;
        else           state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the request on accept; requests in WAIT/RESP are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      be_r    <= '0;
    end else if (latch) begin
      addr_r  <= addr;
      we_r    <= we;
      wdata_r <= wdata;
      be_r    <= be;
    end
  end

  // Keep the response word visible after ready drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              rdata_hold <= '0;
    else if (state == RESP)  rdata_hold <= resp_word;
  end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder: a WAIT_CYCLES=2 instance
// under directed and random traffic, plus a WAIT_CYCLES=0 instance for
// latency and back-to-back spacing.
module tb_mips_data_mem_responder;

  localparam int ADDR_W = 8;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ready, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [31:0] d; bit e; int acc; } exp_t;
  exp_t q[$];

  logic [31:0] mm [0:(1<<ADDR_W)-1];

  mips_data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .rdata(rdata), .err(err));

  mips_data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ready(ready0), .rdata(rdata0), .err(err0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: error if misaligned or beyond the array; else word read or byte merge.
  function automatic exp_t model(input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
    exp_t x;
    int idx;
    logic [31:0] word;
    x.acc = 0;
    if (a[1:0] != 2'b00 || a >= (32'd4 << ADDR_W)) begin
      x.d = 32'd0; x.e = 1'b1;
    end else begin
      idx  = int'(a >> 2);
      word = mm[idx];
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        mm[idx] = word;
      end
      x.d = word; x.e = 1'b0;
    end
    return x;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected ready", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("rdata", rdata, x.d);
        chk("err", {31'd0, err}, {31'd0, x.e});
        chk("latency", cyc - x.acc, W + 1);
      end
    end
  end

  // Issue one request and hold req until ready; optionally toggle req/addr in WAIT.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit busy);
    exp_t x;
    bit got;
    @(negedge clk);
    x = model(w, a, d, b);
    x.acc = cyc + 1;
    q.push_back(x);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
      else if (busy && i == 0) begin
        req = 1'b0; we = 1'b1; addr = 32'h3C; wdata = 32'h0BADF00D; be = 4'hF;
      end else if (busy && i == 1) req = 1'b1;
    end
    if (!got) chk("ready timeout", 32'd0, 32'd1);
    req = 1'b0;
  endtask

  // Store to 0x20, then reset two edges after accept, before the access edge.
  task automatic reset_mid_op();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst ready", {31'd0, ready}, 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Zero-wait instance: latency 1 edge and accepts exactly 3 edges apart.
  task automatic zero_wait_test();
    bit          tw [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ta [5] = '{32'h8, 32'h8, 32'h9, 32'h400, 32'h8};
    logic [31:0] te [5] = '{32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D};
    bit          tx [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int acc, prev;
    bit got;
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = tw[t]; addr0 = ta[t]; wdata0 = 32'hCAFEF00D; be0 = 4'hF;
      acc = cyc + 1;
      if (prev >= 0) chk("w0 spacing", acc - prev, 3);
      prev = acc;
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge clk);
        if (ready0) got = 1'b1;
      end
      chk("w0 latency", got ? cyc - acc : -1, 1);
      chk("w0 rdata", rdata0, te[t]);
      chk("w0 err", {31'd0, err0}, {31'd0, tx[t]});
      req0 = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Give the words used below known contents.
    for (int i = 0; i < 16; i++) issue(1'b1, i * 4, $urandom, 4'hF, 1'b0);

    // Store then load, then byte merge.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    // be=0000 store leaves the word and returns it.
    issue(1'b1, 32'h10, 32'h11223344, 4'b0000, 1'b0);

    // Misaligned load, out-of-range store; word 0 must be untouched.
    issue(1'b0, 32'h11, 32'h0, 4'hF, 1'b0);
    issue(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);

    // Reset mid-store: 0x20 keeps its earlier value.
    reset_mid_op();
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

    // Request toggled during WAIT is ignored; 0x3C stays unchanged.
    issue(1'b0, 32'h14, 32'h0, 4'hF, 1'b1);
    issue(1'b0, 32'h3C, 32'h0, 4'hF, 1'b0);
    repeat (6) @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
        1:       a = ($urandom | 32'h400) & ~32'h3;
        default: a = $urandom_range(0, 15) * 4;
      endcase
      issue($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    zero_wait_test();

    repeat (6) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
